// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the master FSM state type and burst/size helper
// functions used by the burst master and its address generator.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NSEQ,
    ST_BURST,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [4:0] beats_of(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4, HBURST_INCR4:   beats_of = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   beats_of = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats_of = 5'd16;
      default:                      beats_of = 5'd1;
    endcase
  endfunction

  function automatic logic [7:0] step_of(input logic [2:0] size);
    step_of = 8'd1 << size;
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    is_wrap = (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
  endfunction

  // Byte mask of the wrap window; the window is (beats << size) bytes long.
  function automatic logic [11:0] wrap_mask(input logic [2:0] burst, input logic [2:0] size);
    logic [11:0] len;
    len = {7'd0, beats_of(burst)} << size;
    wrap_mask = len - 12'd1;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for an AHB burst: linear increment for
// INCR/SINGLE, wrap inside the aligned burst window for WRAP bursts.
module ahb_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] curAddr_i,
  input  logic [2:0]        size_i,
  input  logic [2:0]        burst_i,
  output logic [ADDR_W-1:0] nextAddr_o
);
  import ahb_pkg::*;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incrAddr;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    step     = ADDR_W'(step_of(size_i));
    incrAddr = curAddr_i + step;
    mask     = ADDR_W'(wrap_mask(burst_i, size_i));
    if (is_wrap(burst_i)) begin
      nextAddr_o = (curAddr_i & ~mask) | (incrAddr & mask);
    end else begin
      nextAddr_o = incrAddr;
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command in, a full pipelined burst out.
// Define AHB_MASTER_ERR_ABORT_EN to cancel the remaining beats on an ERROR response.
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA
);
  import ahb_pkg::*;

  localparam int MAX_SIZE = $clog2(DATA_W / 8);
`ifdef AHB_MASTER_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, nextAddr;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        burst_q, burst_d;
  logic [4:0]        beatsLeft_q, beatsLeft_d;
  logic              dpValid_q, dpValid_d;
  logic              dpWrite_q, dpWrite_d;
  logic              errLatched_q, errLatched_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdataValid_q, rdataValid_d;

  logic [1:0] htrans;
  logic [7:0] sizeMask;
  logic       accept, cmdLegal, respErr, dataDone, abortNow;

  ahb_addr_gen #(.ADDR_W(ADDR_W)) uAddrGen (
    .curAddr_i  (addr_q),
    .size_i     (size_q),
    .burst_i    (burst_q),
    .nextAddr_o (nextAddr)
  );

  // Legality and data-phase status decoded from the registered state.
  always_comb begin
    sizeMask = step_of(cmd_size) - 8'd1;
    cmdLegal = (cmd_size <= 3'(MAX_SIZE)) && (cmd_burst != HBURST_INCR) &&
               ((cmd_addr[7:0] & sizeMask) == 8'd0);
    accept   = cmd_valid && cmd_ready;
    respErr  = dpValid_q && (HRESP != HRESP_OKAY);
    dataDone = dpValid_q && HREADY;
    abortNow = ABORT_EN && respErr && !HREADY;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beatsLeft_d  = beatsLeft_q;
    dpValid_d    = dpValid_q;
    dpWrite_d    = dpWrite_q;
    errLatched_d = errLatched_q | respErr;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    rdataValid_d = 1'b0;
    htrans       = HTRANS_IDLE;

    case (state_q)
      ST_NSEQ:  htrans = HTRANS_NONSEQ;
      ST_BURST: htrans = HTRANS_SEQ;
      default:  htrans = HTRANS_IDLE;
    endcase

    // The pending address phase becomes the data phase whenever the bus advances.
    if (HREADY) begin
      dpValid_d = (htrans != HTRANS_IDLE);
      dpWrite_d = write_q;
    end

    if (dataDone && !dpWrite_q && (HRESP == HRESP_OKAY)) begin
      rdataValid_d = 1'b1;
      rdata_d      = HRDATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmdLegal) begin
            state_d      = ST_NSEQ;
            addr_d       = cmd_addr;
            write_d      = cmd_write;
            size_d       = cmd_size;
            burst_d      = cmd_burst;
            beatsLeft_d  = beats_of(cmd_burst) - 5'd1;
            errLatched_d = 1'b0;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_NSEQ, ST_BURST: begin
        if (abortNow) begin
          state_d = ST_ERR1;
        end else if (HREADY) begin
          if (beatsLeft_q == 5'd0) begin
            state_d = ST_LAST;
          end else begin
            state_d     = ST_BURST;
            addr_d      = nextAddr;
            beatsLeft_d = beatsLeft_q - 5'd1;
          end
        end
      end
      ST_LAST: begin
        if (abortNow) begin
          state_d = ST_ERR1;
        end else if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = errLatched_q | respErr;
        end
      end
      ST_ERR1: begin
        if (HREADY) state_d = ST_ERR2;
      end
      ST_ERR2: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= 3'd0;
      burst_q      <= 3'd0;
      beatsLeft_q  <= 5'd0;
      dpValid_q    <= 1'b0;
      dpWrite_q    <= 1'b0;
      errLatched_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      rdataValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beatsLeft_q  <= beatsLeft_d;
      dpValid_q    <= dpValid_d;
      dpWrite_q    <= dpWrite_d;
      errLatched_q <= errLatched_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      rdataValid_q <= rdataValid_d;
    end
  end

  // Held low during the done pulse so a new command never overlaps it.
  assign cmd_ready   = (state_q == ST_IDLE) && !done_q;
  assign wdata_req   = dataDone && dpWrite_q;
  assign HWDATA      = (dpValid_q && dpWrite_q) ? wdata : '0;
  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign HADDR       = addr_q;
  assign HTRANS      = htrans;
  assign HWRITE      = write_q;
  assign HSIZE       = size_q;
  assign HBURST      = burst_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a table of burst commands run against a
// simple AHB slave model with optional wait states and two-cycle ERROR responses.
module tb_ahb_burst_master;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [1:0] R_OKAY   = 2'b00;
  localparam logic [1:0] R_ERROR  = 2'b01;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size, cmd_burst;
  logic [31:0] wdata, rdata, HADDR, HWDATA, HRDATA;
  logic        wdata_req, rdata_valid, done, err;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    int          stallBeat;
    int          stallCycles;
    int          errBeat;
    int          expBeats;
    logic [31:0] expLastAddr;
    int          expWreq;
    int          expRvalid;
    logic        expErr;
  } vec_t;

  vec_t vecs[12];

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .wdata       (wdata),
    .wdata_req   (wdata_req),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] wPat(input int i);
    return 32'hA5000000 + 32'(i);
  endfunction

  function automatic logic [31:0] rPat(input int i);
    return 32'hC0DE0000 + 32'(i * 32'h101);
  endfunction

  // Reference address of beat idx, written as an offset modulo the wrap window.
  function automatic logic [31:0] modelAddr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [2:0] burst, input int idx);
    int beats;
    int step;
    int len;
    logic [31:0] base;
    logic [31:0] off;
    case (burst)
      3'b000:         beats = 1;
      3'b010, 3'b011: beats = 4;
      3'b100, 3'b101: beats = 8;
      default:        beats = 16;
    endcase
    step = 1 << size;
    len  = beats * step;
    if (burst == 3'b010 || burst == 3'b100 || burst == 3'b110) begin
      base = start & ~(32'(len) - 32'd1);
      off  = ((start - base) + 32'(idx * step)) % 32'(len);
      return base + off;
    end
    return start + 32'(idx * step);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_size  = v.size;
    cmd_burst = v.burst;
    HREADY    = 1'b1;
    HRESP     = R_OKAY;
    #1;
    checkOutput("cmdReady", cmd_ready, 1);
  endtask

  task automatic runBurst(input int n, input vec_t v);
    int addrIdx, wIdx, rIdx, dpBeat, stallLeft, errPhase;
    bit dpActive, seenDone, holdValid, accepted;
    logic errAtDone;
    logic [31:0] holdAddr, lastAddr;
    logic [1:0]  holdTrans;
    addrIdx = 0; wIdx = 0; rIdx = 0; dpBeat = 0; errPhase = 0;
    stallLeft = v.stallCycles;
    dpActive = 0; seenDone = 0; holdValid = 0; errAtDone = 1'b0;
    holdAddr = '0; holdTrans = T_IDLE; lastAddr = '0;
    applyStimulus(v);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && !seenDone; cyc++) begin
      if (cyc != 0) @(negedge HCLK);
      HREADY = 1'b1;
      HRESP  = R_OKAY;
      if (dpActive && dpBeat == v.stallBeat && stallLeft > 0) begin
        HREADY = 1'b0;
        stallLeft--;
      end else if (dpActive && dpBeat == v.errBeat && errPhase == 0) begin
        HREADY   = 1'b0;
        HRESP    = R_ERROR;
        errPhase = 1;
      end else if (errPhase == 1) begin
        HRESP    = R_ERROR;
        errPhase = 2;
      end
      HRDATA = dpActive ? rPat(dpBeat) : '0;
      wdata  = wPat(wIdx);
      #1;
      if (holdValid) begin
        checkOutput($sformatf("v%0d_holdAddr", n), HADDR, holdAddr);
        checkOutput($sformatf("v%0d_holdTrans", n), HTRANS, holdTrans);
      end
      holdValid = 0;
      if (!HREADY && HRESP == R_OKAY && HTRANS[1]) begin
        holdValid = 1;
        holdAddr  = HADDR;
        holdTrans = HTRANS;
      end
`ifdef AHB_MASTER_ERR_ABORT_EN
      if (errPhase == 2 && HRESP == R_ERROR) checkOutput($sformatf("v%0d_err1Idle", n), HTRANS, T_IDLE);
`endif
      if (wdata_req) begin
        checkOutput($sformatf("v%0d_hwdata", n), HWDATA, wPat(wIdx));
        wIdx++;
      end
      if (rdata_valid) begin
        checkOutput($sformatf("v%0d_rdata", n), rdata, rPat(rIdx));
        rIdx++;
      end
      accepted = HTRANS[1] && HREADY;
      if (accepted) begin
        checkOutput($sformatf("v%0d_htrans%0d", n, addrIdx), HTRANS, (addrIdx == 0) ? T_NONSEQ : T_SEQ);
        checkOutput($sformatf("v%0d_haddr%0d", n, addrIdx), HADDR,
                    modelAddr(v.addr, v.size, v.burst, addrIdx));
        lastAddr = HADDR;
      end
      if (HREADY) begin
        dpActive = accepted;
        if (accepted) dpBeat = addrIdx;
      end
      if (accepted) addrIdx++;
      if (done) begin
        seenDone  = 1;
        errAtDone = err;
        checkOutput($sformatf("v%0d_readyAtDone", n), cmd_ready, 0);
      end
    end
    checkOutput($sformatf("v%0d_doneSeen", n), seenDone, 1);
    checkOutput($sformatf("v%0d_beats", n), addrIdx, v.expBeats);
    if (v.expBeats > 0) checkOutput($sformatf("v%0d_lastAddr", n), lastAddr, v.expLastAddr);
    checkOutput($sformatf("v%0d_wreqCount", n), wIdx, v.expWreq);
    checkOutput($sformatf("v%0d_rvalidCount", n), rIdx, v.expRvalid);
    checkOutput($sformatf("v%0d_err", n), errAtDone, v.expErr);
    @(negedge HCLK);
    HREADY = 1'b1;
    HRESP  = R_OKAY;
    #1;
    checkOutput($sformatf("v%0d_donePulse", n), done, 0);
    checkOutput($sformatf("v%0d_readyAfter", n), cmd_ready, 1);
    checkOutput($sformatf("v%0d_idleAfter", n), HTRANS, T_IDLE);
  endtask

  initial begin
    vec_t v;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = 3'd0; cmd_burst = 3'd0; wdata = '0; HREADY = 1'b1;
    HRESP = R_OKAY; HRDATA = '0;

    //        wr    addr          size  burst   stB stC errB beats lastAddr      wreq rv err
    vecs[0]  = '{1'b1, 32'h84000000, 3'd2, 3'b000, -1, 0, -1, 1,  32'h84000000, 1,  0, 1'b0};
    vecs[1]  = '{1'b0, 32'h84000000, 3'd2, 3'b011, -1, 0, -1, 4,  32'h8400000C, 0,  4, 1'b0};
    vecs[2]  = '{1'b1, 32'h84000008, 3'd2, 3'b010, -1, 0, -1, 4,  32'h84000004, 4,  0, 1'b0};
    vecs[3]  = '{1'b0, 32'h84000000, 3'd2, 3'b101,  1, 3, -1, 8,  32'h8400001C, 0,  8, 1'b0};
`ifdef AHB_MASTER_ERR_ABORT_EN
    vecs[4]  = '{1'b1, 32'h84000010, 3'd2, 3'b100, -1, 0,  2, 3,  32'h84000018, 3,  0, 1'b1};
`else
    vecs[4]  = '{1'b1, 32'h84000010, 3'd2, 3'b100, -1, 0,  2, 8,  32'h8400000C, 8,  0, 1'b1};
`endif
    vecs[5]  = '{1'b1, 32'h84000002, 3'd2, 3'b000, -1, 0, -1, 0,  32'h00000000, 0,  0, 1'b1};
    vecs[6]  = '{1'b0, 32'h84000000, 3'd3, 3'b011, -1, 0, -1, 0,  32'h00000000, 0,  0, 1'b1};
    vecs[7]  = '{1'b0, 32'h84000000, 3'd2, 3'b001, -1, 0, -1, 0,  32'h00000000, 0,  0, 1'b1};
    vecs[8]  = '{1'b0, 32'h8400001E, 3'd1, 3'b110, -1, 0, -1, 16, 32'h8400001C, 0, 16, 1'b0};
    vecs[9]  = '{1'b1, 32'h84000005, 3'd0, 3'b111, -1, 0, -1, 16, 32'h84000014, 16, 0, 1'b0};
    vecs[10] = '{1'b0, 32'h84000003, 3'd0, 3'b010, -1, 0, -1, 4,  32'h84000002, 0,  4, 1'b0};
    vecs[11] = '{1'b0, 32'h84000040, 3'd2, 3'b000, -1, 0,  0, 1,  32'h84000040, 0,  0, 1'b1};

    repeat (3) @(negedge HCLK);
    #1;
    checkOutput("rstHtrans", HTRANS, T_IDLE);
    checkOutput("rstHaddr", HADDR, 0);
    checkOutput("rstHwrite", HWRITE, 0);
    checkOutput("rstHsize", HSIZE, 0);
    checkOutput("rstHburst", HBURST, 0);
    checkOutput("rstHwdata", HWDATA, 0);
    checkOutput("rstCmdReady", cmd_ready, 1);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstRvalid", rdata_valid, 0);
    checkOutput("rstWreq", wdata_req, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runBurst(i, vecs[i]);
    end

    // Asynchronous reset in the middle of an INCR16 read.
    v = '{1'b0, 32'h84000000, 3'd2, 3'b111, -1, 0, -1, 16, 32'h8400003C, 0, 16, 1'b0};
    applyStimulus(v);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    HRDATA    = '0;
    repeat (3) @(negedge HCLK);
    #1;
    checkOutput("preResetTrans", HTRANS, T_SEQ);
    HRESETn = 1'b0;
    #1;
    checkOutput("midRstHtrans", HTRANS, T_IDLE);
    checkOutput("midRstHaddr", HADDR, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstReady", cmd_ready, 1);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      #1;
      checkOutput($sformatf("postRstDone%0d", c), done, 0);
      checkOutput($sformatf("postRstTrans%0d", c), HTRANS, T_IDLE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
